// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle control unit.
package kgp_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   // Opcodes (compared after zero-extension to 32 bits)
   localparam int unsigned OP_RTYPE = 0;
   localparam int unsigned OP_ADDI  = 1;
   localparam int unsigned OP_COMPI = 2;
   localparam int unsigned OP_LW    = 3;
   localparam int unsigned OP_SW    = 4;
   localparam int unsigned OP_B     = 5;
   localparam int unsigned OP_BR    = 6;
   localparam int unsigned OP_BLTZ  = 7;
   localparam int unsigned OP_BZ    = 8;
   localparam int unsigned OP_BNZ   = 9;
   localparam int unsigned OP_BL    = 10;
   localparam int unsigned OP_BCY   = 11;
   localparam int unsigned OP_BNCY  = 12;
   localparam int unsigned OP_HALT  = 63;

   // R-type function codes
   localparam int unsigned FN_ADD   = 0;
   localparam int unsigned FN_COMP  = 1;
   localparam int unsigned FN_AND   = 2;
   localparam int unsigned FN_XOR   = 3;
   localparam int unsigned FN_SHLL  = 4;
   localparam int unsigned FN_SHRL  = 5;
   localparam int unsigned FN_SHLLV = 6;
   localparam int unsigned FN_SHRLV = 7;
   localparam int unsigned FN_SHRA  = 8;
   localparam int unsigned FN_SHRAV = 9;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_COMP = 3'd1,
      ALU_AND  = 3'd2,
      ALU_XOR  = 3'd3,
      ALU_SHL  = 3'd4,
      ALU_SHRL = 3'd5,
      ALU_SHRA = 3'd6,
      ALU_PASS = 3'd7
   } aluop_t;

   typedef enum logic [1:0] {
      SRC_RT    = 2'd0,
      SRC_IMM   = 2'd1,
      SRC_SHAMT = 2'd2
   } alusrc_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_LABEL = 2'd1,
      PC_RS    = 2'd2
   } pcsrc_t;

   function automatic logic isKnownOpcode(input logic [31:0] op);
      return (op <= OP_BNCY) || (op == OP_HALT);
   endfunction

   function automatic logic isBranch(input logic [31:0] op);
      return (op >= OP_B) && (op <= OP_BNCY);
   endfunction

endpackage

// File: rtl/kgp_alu_decode.sv
// Combinational opcode/funccode to ALU control map used during EXEC.
module kgp_alu_decode
   import kgp_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 5
) (
   input  logic [OPW-1:0] opcode,
   input  logic [FNW-1:0] funccode,
   output aluop_t         aluOp,
   output alusrc_t        aluSrc,
   output logic           aluFrc
);

   logic [31:0] opc;
   logic [31:0] fnc;

   assign opc = 32'(opcode);
   assign fnc = 32'(funccode);

   // Constant shifts take the shift amount field; variable shifts read RT.
   always_comb begin
      aluOp  = ALU_ADD;
      aluSrc = SRC_RT;
      aluFrc = 1'b0;
      case (opc)
         OP_RTYPE: begin
            case (fnc)
               FN_COMP:  aluOp = ALU_COMP;
               FN_AND:   aluOp = ALU_AND;
               FN_XOR:   aluOp = ALU_XOR;
               FN_SHLL:  begin aluOp = ALU_SHL;  aluSrc = SRC_SHAMT; end
               FN_SHRL:  begin aluOp = ALU_SHRL; aluSrc = SRC_SHAMT; end
               FN_SHLLV: aluOp = ALU_SHL;
               FN_SHRLV: aluOp = ALU_SHRL;
               FN_SHRA:  begin aluOp = ALU_SHRA; aluSrc = SRC_SHAMT; end
               FN_SHRAV: aluOp = ALU_SHRA;
               default:  aluOp = ALU_ADD;
            endcase
         end
         OP_ADDI: begin
            aluSrc = SRC_IMM;
            aluFrc = 1'b1;
         end
         OP_COMPI: begin
            aluOp  = ALU_COMP;
            aluSrc = SRC_IMM;
            aluFrc = 1'b1;
         end
         OP_LW, OP_SW: aluSrc = SRC_IMM;
         OP_B, OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BL, OP_BCY, OP_BNCY:
            aluOp = ALU_PASS;
         default: aluOp = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multi-cycle KGP-RISC control unit: sequences fetch, decode, execute,
// memory and write-back with req/ready handshakes and a wait timeout.
module kgp_control_fsm
   import kgp_ctrl_pkg::*;
#(
   parameter int OPW         = 6,
   parameter int FNW         = 5,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic [FNW-1:0] funccode,
   input  logic           zeroFlag,
   input  logic           negFlag,
   input  logic           carryFlag,
   input  logic           imem_ready,
   input  logic           dmem_ready,
   output logic           imem_req,
   output logic           dmem_req,
   output logic           ir_write,
   output logic           pc_write,
   output logic [1:0]     pc_src,
   output logic [2:0]     ALUResOp,
   output logic [1:0]     ALUSrc,
   output logic           ALUFrc,
   output logic           brLink,
   output logic           memToReg,
   output logic           memRead,
   output logic           memWrite,
   output logic           regWrite,
   output logic           halted,
   output logic           err
);

   localparam int CNTW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNTW-1:0] LAST_WAIT = CNTW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
   localparam bit TIMEOUT_ON = (MEM_TIMEOUT != 0);

   state_t          state, nextState;
   logic [CNTW-1:0] waitCnt;
   logic            carryQ;
   logic            errQ, nextErr;
   logic            loadCarry;
   logic            taken;
   logic            timedOut;
   logic [31:0]     opc;
   aluop_t          decOp;
   alusrc_t         decSrc;
   logic            decFrc;

   assign opc      = 32'(opcode);
   // The last permitted wait cycle without ready gives up the request.
   assign timedOut = TIMEOUT_ON && (waitCnt == LAST_WAIT);

   kgp_alu_decode #(
      .OPW(OPW),
      .FNW(FNW)
   ) uAluDecode (
      .opcode  (opcode),
      .funccode(funccode),
      .aluOp   (decOp),
      .aluSrc  (decSrc),
      .aluFrc  (decFrc)
   );

   // State, error, carry and wait-counter registers; counter restarts on every state change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_FETCH;
         waitCnt <= '0;
         carryQ  <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         state   <= nextState;
         errQ    <= nextErr;
         waitCnt <= (nextState != state) ? '0 : waitCnt + CNTW'(1);
         if (loadCarry) carryQ <= carryFlag;
      end
   end

   // Next-state and Moore output decode; everything forced low while in reset.
   always_comb begin
      nextState = state;
      nextErr   = errQ;
      loadCarry = 1'b0;
      taken     = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      ALUResOp  = ALU_ADD;
      ALUSrc    = SRC_RT;
      ALUFrc    = 1'b0;
      brLink    = 1'b0;
      memToReg  = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      halted    = 1'b0;
      err       = 1'b0;
      if (rst) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write  = 1'b1;
                  nextState = S_DECODE;
               end else if (timedOut) begin
                  nextState = S_HALT;
                  nextErr   = 1'b1;
               end
            end
            S_DECODE: begin
               if (opc == OP_HALT) begin
                  nextState = S_HALT;
               end else if (!isKnownOpcode(opc)) begin
                  nextState = S_HALT;
                  nextErr   = 1'b1;
               end else begin
                  nextState = S_EXEC;
               end
            end
            S_EXEC: begin
               ALUResOp  = decOp;
               ALUSrc    = decSrc;
               ALUFrc    = decFrc;
               loadCarry = (decOp == ALU_ADD) || (decOp == ALU_COMP);
               if (isBranch(opc)) begin
                  case (opc)
                     OP_B, OP_BR: taken = 1'b1;
                     OP_BLTZ:     taken = negFlag;
                     OP_BZ:       taken = zeroFlag;
                     OP_BNZ:      taken = !zeroFlag;
                     OP_BL: begin
                        taken    = 1'b1;
                        brLink   = 1'b1;
                        regWrite = 1'b1;
                     end
                     OP_BCY:      taken = carryQ;
                     OP_BNCY:     taken = !carryQ;
                     default:     taken = 1'b0;
                  endcase
                  pc_write  = 1'b1;
                  pc_src    = (opc == OP_BR) ? PC_RS : (taken ? PC_LABEL : PC_PLUS4);
                  nextState = S_FETCH;
               end else if ((opc == OP_LW) || (opc == OP_SW)) begin
                  nextState = S_MEM;
               end else begin
                  nextState = S_WB;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               memRead  = (opc == OP_LW);
               memWrite = (opc == OP_SW);
               if (dmem_ready) begin
                  if (opc == OP_SW) begin
                     pc_write  = 1'b1;
                     nextState = S_FETCH;
                  end else begin
                     nextState = S_WB;
                  end
               end else if (timedOut) begin
                  nextState = S_HALT;
                  nextErr   = 1'b1;
               end
            end
            S_WB: begin
               regWrite  = 1'b1;
               memToReg  = (opc == OP_LW);
               pc_write  = 1'b1;
               nextState = S_FETCH;
            end
            S_HALT: begin
               halted = 1'b1;
               err    = errQ;
            end
            default: nextState = S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Randomized self-checking bench for kgp_control_fsm against a per-instruction
// cycle-script reference model.
module tb_kgp_control_fsm;

   localparam int TO = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] opcode = '0;
   logic [4:0] funccode = '0;
   logic       zeroFlag = 1'b0, negFlag = 1'b0, carryFlag = 1'b0;
   logic       imem_ready = 1'b0, dmem_ready = 1'b0;
   logic       imem_req, dmem_req, ir_write, pc_write;
   logic [1:0] pc_src;
   logic [2:0] ALUResOp;
   logic [1:0] ALUSrc;
   logic       ALUFrc, brLink, memToReg, memRead, memWrite, regWrite, halted, err;

   kgp_control_fsm #(.OPW(6), .FNW(5), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funccode(funccode),
      .zeroFlag(zeroFlag), .negFlag(negFlag), .carryFlag(carryFlag),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .ALUResOp(ALUResOp), .ALUSrc(ALUSrc), .ALUFrc(ALUFrc),
      .brLink(brLink), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
      .regWrite(regWrite), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       imemReq, dmemReq, irWrite, pcWrite;
      logic [1:0] pcSrc;
      logic [2:0] aluOp;
      logic [1:0] aluSrc;
      logic       aluFrc, brLink, memToReg, memRead, memWrite, regWrite, halted, err;
   } ov_t;

   typedef struct {
      bit         iR, dR, z, n, c;
      logic [5:0] op;
      logic [4:0] fn;
      ov_t        e;
   } cyc_t;

   // Spec table for R-type funccodes 0..9: ALU op and operand source
   int fnOp  [10] = '{0, 1, 2, 3, 4, 5, 4, 5, 6, 6};
   int fnSrc [10] = '{0, 0, 0, 0, 2, 2, 0, 0, 2, 0};

   cyc_t q[$];
   bit   mCarry, mHalted;
   int   curOp, curFn;
   int   nVec = 0, nErr = 0;

   task automatic chkVec(input string tag, input logic [18:0] got, input logic [18:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   function automatic ov_t outVec();
      return ov_t'({imem_req, dmem_req, ir_write, pc_write, pc_src, ALUResOp, ALUSrc,
                    ALUFrc, brLink, memToReg, memRead, memWrite, regWrite, halted, err});
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic void push(ov_t e, bit iR, bit dR, bit z, bit n, bit c);
      cyc_t x;
      x.e = e; x.iR = iR; x.dR = dR; x.z = z; x.n = n; x.c = c;
      x.op = 6'(curOp); x.fn = 5'(curFn);
      q.push_back(x);
   endfunction

   function automatic void haltFor(bit er);
      ov_t e;
      for (int k = 0; k < 4; k++) begin
         e = '0; e.halted = 1'b1; e.err = er;
         push(e, rb(), rb(), rb(), rb(), rb());
      end
      mHalted = 1'b1;
   endfunction

   function automatic void newEpisode();
      q.delete();
      mCarry  = 1'b0;
      mHalted = 1'b0;
   endfunction

   // Appends the expected cycle script of one instruction.
   function automatic void addInstr(int op, int fn, int iw, int dw, bit z, bit n, bit c);
      ov_t e;
      bit  tk;
      bit  arith;
      if (mHalted) return;
      curOp = op; curFn = fn;
      for (int k = 0; k < iw && k < TO; k++) begin
         e = '0; e.imemReq = 1'b1;
         push(e, 1'b0, rb(), rb(), rb(), rb());
      end
      if (iw >= TO) begin haltFor(1'b1); return; end
      e = '0; e.imemReq = 1'b1; e.irWrite = 1'b1;
      push(e, 1'b1, rb(), rb(), rb(), rb());
      e = '0;
      push(e, rb(), rb(), rb(), rb(), rb());
      if (op == 63) begin haltFor(1'b0); return; end
      if (op > 12) begin haltFor(1'b1); return; end
      // execute
      e = '0;
      arith = 1'b0;
      if (op == 0) begin
         e.aluOp = 3'(fnOp[fn]); e.aluSrc = 2'(fnSrc[fn]); arith = (fn <= 1);
      end else if (op == 1 || op == 2) begin
         e.aluOp = (op == 2) ? 3'd1 : 3'd0; e.aluSrc = 2'd1; e.aluFrc = 1'b1; arith = 1'b1;
      end else if (op == 3 || op == 4) begin
         e.aluSrc = 2'd1; arith = 1'b1;
      end else begin
         e.aluOp = 3'd7; e.pcWrite = 1'b1;
         case (op)
            7:       tk = n;
            8:       tk = z;
            9:       tk = !z;
            11:      tk = mCarry;
            12:      tk = !mCarry;
            default: tk = 1'b1;
         endcase
         e.pcSrc = (op == 6) ? 2'd2 : (tk ? 2'd1 : 2'd0);
         if (op == 10) begin e.brLink = 1'b1; e.regWrite = 1'b1; end
         push(e, rb(), rb(), z, n, c);
         return;
      end
      push(e, rb(), rb(), z, n, c);
      if (arith) mCarry = c;
      if (op == 3 || op == 4) begin
         for (int k = 0; k < dw && k < TO; k++) begin
            e = '0; e.dmemReq = 1'b1; e.memRead = (op == 3); e.memWrite = (op == 4);
            push(e, rb(), 1'b0, rb(), rb(), rb());
         end
         if (dw >= TO) begin haltFor(1'b1); return; end
         e = '0; e.dmemReq = 1'b1; e.memRead = (op == 3); e.memWrite = (op == 4);
         e.pcWrite = (op == 4);
         push(e, rb(), 1'b1, rb(), rb(), rb());
         if (op == 4) return;
      end
      e = '0; e.regWrite = 1'b1; e.memToReg = (op == 3); e.pcWrite = 1'b1;
      push(e, rb(), rb(), rb(), rb(), rb());
   endfunction

   // Resets the DUT, checks the reset outputs, then plays the script (up to limit entries).
   task automatic runEpisode(input string name, input int limit);
      rst = 1'b0;
      imem_ready = 1'b1; dmem_ready = 1'b1;
      opcode = 6'(q.size() > 0 ? q[0].op : 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chkVec({name, ":rst"}, outVec(), '0);
      for (int i = 0; i < q.size() && (limit < 0 || i < limit); i++) begin
         @(posedge clk);
         #1;
         rst = 1'b1;
         imem_ready = q[i].iR; dmem_ready = q[i].dR;
         zeroFlag = q[i].z; negFlag = q[i].n; carryFlag = q[i].c;
         opcode = q[i].op; funccode = q[i].fn;
         @(negedge clk);
         chkVec($sformatf("%s#%0d", name, i), outVec(), q[i].e);
      end
   endtask

   initial begin
      // ALU op then next fetch
      newEpisode(); addInstr(0, 0, 0, 0, 0, 0, 0); addInstr(0, 3, 0, 0, 1, 0, 0);
      runEpisode("alu", -1);
      // lw with data memory 3 cycles late
      newEpisode(); addInstr(3, 0, 0, 3, 0, 0, 1); addInstr(0, 2, 0, 0, 0, 0, 0);
      runEpisode("lw", -1);
      // bz taken / not taken
      newEpisode(); addInstr(8, 0, 0, 0, 1, 0, 0); addInstr(8, 0, 1, 0, 0, 0, 0);
      runEpisode("bz", -1);
      // carry tracking through bcy / bncy
      newEpisode();
      addInstr(0, 0, 0, 0, 0, 0, 1); addInstr(11, 0, 0, 0, 0, 0, 0);
      addInstr(2, 0, 0, 0, 0, 0, 0); addInstr(12, 0, 0, 0, 0, 0, 1);
      addInstr(0, 3, 0, 0, 0, 0, 1); addInstr(12, 0, 0, 0, 0, 0, 0);
      runEpisode("carry", -1);
      // bl, br, bltz
      newEpisode(); addInstr(10, 0, 0, 0, 0, 0, 0); addInstr(6, 0, 0, 0, 0, 0, 0);
      addInstr(7, 0, 0, 0, 0, 1, 0); addInstr(7, 0, 0, 0, 0, 0, 0);
      runEpisode("bl", -1);
      // invalid opcode and explicit halt
      newEpisode(); addInstr(0, 8, 0, 0, 0, 0, 0); addInstr(42, 0, 0, 0, 0, 0, 0);
      runEpisode("badop", -1);
      newEpisode(); addInstr(4, 0, 0, 0, 0, 0, 0); addInstr(63, 0, 0, 0, 0, 0, 0);
      runEpisode("haltop", -1);
      // instruction memory: ready on the last allowed cycle, then a full timeout
      newEpisode(); addInstr(1, 0, TO - 1, 0, 0, 0, 0); addInstr(0, 0, TO, 0, 0, 0, 0);
      runEpisode("itimeout", -1);
      // data memory timeout on sw
      newEpisode(); addInstr(4, 0, 0, TO + 20, 0, 0, 0);
      runEpisode("dtimeout", -1);
      // reset asserted in the middle of a data memory wait
      newEpisode(); addInstr(3, 0, 0, 10, 0, 0, 0);
      runEpisode("rstmem", 5);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chkVec("rstmem:drop", outVec(), '0);
      newEpisode(); addInstr(0, 1, 0, 0, 0, 0, 0);
      runEpisode("afterrst", -1);
      // randomized instruction streams
      for (int ep = 0; ep < 40; ep++) begin
         int nIns;
         int tail;
         newEpisode();
         nIns = $urandom_range(3, 8);
         for (int k = 0; k < nIns; k++)
            addInstr($urandom_range(0, 12), $urandom_range(0, 9),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     rb(), rb(), rb());
         tail = $urandom_range(0, 3);
         if (tail == 0) addInstr(63, 0, 0, 0, 0, 0, 0);
         else if (tail == 1) addInstr($urandom_range(13, 62), 0, 0, 0, 0, 0, 0);
         runEpisode($sformatf("rnd%0d", ep), -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/kgp_control_fsm.md
Name: kgp_control_fsm

Overview:
- Multi-cycle control unit for the KGP-RISC datapath; the producing end of the datapath control interface.
- Consumes opcode/funccode from the datapath IR plus ALU flags.
- Drives every datapath control strobe, the PC update, and req/ready handshakes to the instruction and data memories.
- Replaces single-cycle combinational control so both memories may take multiple cycles.

Parameters:
- OPW, 6, opcode width
- FNW, 5, funccode width
- MEM_TIMEOUT, 255, cycles waited for a ready before entering HALT with err set (0 disables)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous and active-low (0 = reset)
- opcode  in  OPW  IR opcode, stable after ir_write
- funccode  in  FNW  IR funccode
- zeroFlag, negFlag, carryFlag  in  1 each  combinational ALU flags in EXEC
- imem_ready, dmem_ready  in  1 each  memory completion
- imem_req, dmem_req  out  1 each  memory request, held until ready
- ir_write, pc_write  out  1 each  IR / PC load strobes
- pc_src  out  2  0 = PC+4, 1 = label, 2 = RS
- ALUResOp  out  3  0 ADD, 1 COMP, 2 AND, 3 XOR, 4 SHL, 5 SHRL, 6 SHRA, 7 PASS
- ALUSrc  out  2  0 = RT, 1 = imm, 2 = shamt
- ALUFrc, brLink, memToReg, memRead, memWrite, regWrite  out  1 each
- halted, err  out  1 each  status

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- Outputs are Moore-decoded from state plus opcode/funccode. All outputs are 0 while rst=0; asserting rst mid-transaction clears them immediately, including dropping any request.
- FETCH:
  - imem_req=1 until imem_ready.
  - On the ready cycle: ir_write=1, go to DECODE.
- DECODE: one cycle, register read only, no strobes.
  - Opcode not in the package table -> HALT, err=1.
  - Opcode 6'h3F -> HALT, err=0.
- EXEC, R-type (opcode 0): ALUResOp from funccode; ALUSrc=2 for constant shifts, else 0 -> WB.
- EXEC, addi/compi: ALUFrc=1, ALUSrc=1 -> WB.
- EXEC, lw/sw: ADD, ALUSrc=1 -> MEM.
- EXEC, branches: ALUResOp=PASS on RS; pc_write=1 this cycle; return to FETCH.
  - pc_src=1 (label) when taken, 0 when not taken.
  - br uses pc_src=2 and is always taken.
  - bltz: taken on negFlag. bz: taken on zeroFlag. bnz: taken on !zeroFlag.
  - bcy / bncy: taken on carry_q / !carry_q.
  - bl: additionally brLink=1 and regWrite=1 in the same cycle (r31 <= PC+4).
- carry_q:
  - Loaded from carryFlag at the end of EXEC for ADD/COMP ops only.
  - Reset value 0; held across all other instructions.
- MEM:
  - dmem_req=1 with memRead (lw) or memWrite (sw); all held steady until dmem_ready.
  - sw: pc_write=1, pc_src=0 on the ready cycle -> FETCH.
  - lw: -> WB.
- WB: regWrite=1, memToReg=1 for lw, pc_write=1, pc_src=0 -> FETCH. Exactly one regWrite pulse per instruction.
- Request timeout: a wait counter is cleared on entry to FETCH or MEM.
  - If it reaches MEM_TIMEOUT without ready: go to HALT, err=1, request dropped.
- Ready sampled in the same cycle the request rises counts (zero-wait memory).
- Ready arriving outside FETCH or MEM is ignored.
- HALT: halted=1; all strobes 0; leaves only on reset.
- Latency with zero-wait memories:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - sw: 4 cycles; lw: 5 cycles.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - state enum
  - opcode constants (0 R-type, 1 addi, 2 compi, 3 lw, 4 sw, 5 b, 6 br, 7 bltz, 8 bz, 9 bnz, 10 bl, 11 bcy, 12 bncy, 63 halt)
  - funccode constants (0 add, 1 comp, 2 and, 3 xor, 4 shll, 5 shrl, 6 shllv, 7 shrlv, 8 shra, 9 shrav)
  - ALUResOp, ALUSrc and pc_src encodings
- One sub-module, kgp_alu_decode: combinational map opcode/funccode -> {ALUResOp, ALUSrc, ALUFrc}.

Test Plan:
- Reset released, imem_ready=1 constant, opcode 0 / funccode 0 -> imem_req and ir_write in cycle 1, regWrite=1 and pc_write=1 with pc_src=0 in cycle 4, next imem_req in cycle 5.
- lw with dmem_ready delayed 3 cycles -> dmem_req=1, memRead=1 steady for 4 cycles, then WB with regWrite=1, memToReg=1; total 8 cycles.
- bz with zeroFlag=1 -> EXEC pc_write=1, pc_src=1; with zeroFlag=0 -> pc_src=0; no regWrite in either case.
- add producing carryFlag=1 followed by bcy -> taken (pc_src=1); then compi with carryFlag=0 followed by bncy -> taken.
- bl -> brLink=1, regWrite=1, pc_write=1, pc_src=1 all in one EXEC cycle.
- opcode 6'h2A -> HALT, err=1, halted=1; imem_ready held 0 for 255 cycles -> HALT, err=1; rst pulled low mid-MEM -> dmem_req drops the same cycle, FETCH after release.
